// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, the fetch state encoding and
// per-icode layout helpers used by fetch and by the pipelined core.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_IDLE  = 2'd1,
        S_FETCH = 2'd2,
        S_HOLD  = 2'd3
    } fetch_state_e;

    // Invalid icodes are treated as one-byte instructions.
    function automatic logic [3:0] ilen(input logic [3:0] icode);
        case (icode)
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: ilen = 4'd2;
            I_JXX, I_CALL:                    ilen = 4'd9;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:     ilen = 4'd10;
            default:                          ilen = 4'd1;
        endcase
    endfunction

    function automatic logic has_regs(input logic [3:0] icode);
        case (icode)
            I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
            I_OPQ, I_PUSHQ, I_POPQ:           has_regs = 1'b1;
            default:                          has_regs = 1'b0;
        endcase
    endfunction

    function automatic logic has_valc(input logic [3:0] icode);
        case (icode)
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
            I_JXX, I_CALL:                    has_valc = 1'b1;
            default:                          has_valc = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/y86_fetch_unit_if.sv
// Fetch-stage bus: PC load from PC-update, byte-wide imem handshake and the
// decoded-instruction handshake toward decode.
interface y86_fetch_unit_if;
    logic [63:0] pc_new;
    logic        pc_load;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [7:0]  imem_rdata;
    logic        imem_rvalid;
    logic        imem_err;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
    logic        instr_invalid;
    logic        mem_error;

    modport master (
        input  pc_new, pc_load, imem_rdata, imem_rvalid, imem_err, out_ready,
        output imem_req, imem_addr, out_valid, icode, ifun, rA, rB, valC, valP,
               instr_invalid, mem_error
    );

    modport slave (
        output pc_new, pc_load, imem_rdata, imem_rvalid, imem_err, out_ready,
        input  imem_req, imem_addr, out_valid, icode, ifun, rA, rB, valC, valP,
               instr_invalid, mem_error
    );
endinterface

// File: rtl/y86_ilen.sv
// Combinational instruction-layout decode from icode; shared with the
// pipelined core.
module y86_ilen
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    output logic [3:0] len,
    output logic       needs_regs,
    output logic       needs_valc,
    output logic [3:0] valc_offset,
    output logic       invalid
);

    // Layout lookup; valC follows the register byte when one is present.
    always_comb begin
        len         = ilen(icode);
        needs_regs  = has_regs(icode);
        needs_valc  = has_valc(icode);
        invalid     = (icode > I_POPQ);
        if (needs_regs) begin
            valc_offset = 4'd2;
        end else begin
            valc_offset = 4'd1;
        end
    end

endmodule

// File: rtl/y86_fetch_unit.sv
// Byte-serial Y86-64 fetch stage: reads one instruction byte per accepted
// imem handshake, assembles the fields and holds them until decode accepts.
module y86_fetch_unit
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    y86_fetch_unit_if.master     bus
);

    fetch_state_e state_r;
    fetch_state_e state_next_s;

    logic [63:0] pc_r;
    logic [3:0]  byte_cnt_r;
    logic [3:0]  icode_r;
    logic [3:0]  ifun_r;
    logic [3:0]  ra_r;
    logic [3:0]  rb_r;
    logic [63:0] valc_r;
    logic [63:0] valp_r;
    logic        out_valid_r;
    logic        invalid_r;
    logic        mem_error_r;

    logic [3:0]  len_icode_s;
    logic [3:0]  len_s;
    logic        needs_regs_s;
    logic        needs_valc_s;
    logic [3:0]  valc_offset_s;
    logic        len_invalid_s;
    logic        accept_s;
    logic        last_byte_s;
    logic [3:0]  valc_byte_s;

    // On byte 0 the layout must come from the byte on the bus, not the cleared icode.
    assign len_icode_s = (byte_cnt_r == 4'd0) ? bus.imem_rdata[7:4] : icode_r;

    y86_ilen u_ilen (
        .icode       (len_icode_s),
        .len         (len_s),
        .needs_regs  (needs_regs_s),
        .needs_valc  (needs_valc_s),
        .valc_offset (valc_offset_s),
        .invalid     (len_invalid_s)
    );

    assign accept_s    = (state_r == S_FETCH) && bus.imem_rvalid;
    assign last_byte_s = (byte_cnt_r == (len_s - 4'd1));
    assign valc_byte_s = byte_cnt_r - valc_offset_s;

    assign bus.imem_req      = (state_r == S_FETCH);
    assign bus.imem_addr     = pc_r + {60'd0, byte_cnt_r};
    assign bus.out_valid     = out_valid_r;
    assign bus.icode         = icode_r;
    assign bus.ifun          = ifun_r;
    assign bus.rA            = ra_r;
    assign bus.rB            = rb_r;
    assign bus.valC          = valc_r;
    assign bus.valP          = valp_r;
    assign bus.instr_invalid = invalid_r;
    assign bus.mem_error     = mem_error_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_START;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_START: state_next_s = S_FETCH;
            S_IDLE: begin
                if (bus.pc_load) begin
                    state_next_s = S_FETCH;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_FETCH: begin
                if (accept_s && (bus.imem_err || last_byte_s)) begin
                    state_next_s = S_HOLD;
                end else begin
                    state_next_s = S_FETCH;
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_HOLD;
                end
            end
            default: state_next_s = S_START;
        endcase
    end

    // Datapath: PC capture, byte collection and field clearing after handoff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r        <= RESET_PC;
            byte_cnt_r  <= 4'd0;
            icode_r     <= 4'd0;
            ifun_r      <= 4'd0;
            ra_r        <= RNONE;
            rb_r        <= RNONE;
            valc_r      <= 64'd0;
            valp_r      <= 64'd0;
            out_valid_r <= 1'b0;
            invalid_r   <= 1'b0;
            mem_error_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.pc_load) begin
                        pc_r <= bus.pc_new;
                    end
                end
                S_FETCH: begin
                    if (accept_s) begin
                        if (bus.imem_err) begin
                            // The faulting byte counts toward valP but its data is dropped.
                            mem_error_r <= 1'b1;
                            valp_r      <= pc_r + {60'd0, byte_cnt_r} + 64'd1;
                            out_valid_r <= 1'b1;
                        end else begin
                            if (byte_cnt_r == 4'd0) begin
                                icode_r   <= bus.imem_rdata[7:4];
                                ifun_r    <= bus.imem_rdata[3:0];
                                invalid_r <= len_invalid_s;
                            end else if (needs_regs_s && (byte_cnt_r == 4'd1)) begin
                                ra_r <= bus.imem_rdata[7:4];
                                rb_r <= bus.imem_rdata[3:0];
                            end else if (needs_valc_s) begin
                                for (int i = 0; i < 8; i++) begin
                                    if (valc_byte_s == 4'(i)) begin
                                        valc_r[i*8 +: 8] <= bus.imem_rdata;
                                    end
                                end
                            end
                            if (last_byte_s) begin
                                valp_r      <= pc_r + {60'd0, len_s};
                                out_valid_r <= 1'b1;
                            end else begin
                                byte_cnt_r <= byte_cnt_r + 4'd1;
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.out_ready) begin
                        byte_cnt_r  <= 4'd0;
                        icode_r     <= 4'd0;
                        ifun_r      <= 4'd0;
                        ra_r        <= RNONE;
                        rb_r        <= RNONE;
                        valc_r      <= 64'd0;
                        valp_r      <= 64'd0;
                        out_valid_r <= 1'b0;
                        invalid_r   <= 1'b0;
                        mem_error_r <= 1'b0;
                    end
                end
                default: begin
                    byte_cnt_r <= 4'd0;
                end
            endcase
        end
    end

endmodule
